vec_dispatch: RTL and testbench
===============================

VEC_DISPATCH -- requirements
Module: vec_dispatch

Interface
REQ-001 The block SHALL have parameter BUS_WIDTH, default 128, the sub-vector word width.
REQ-002 The block SHALL have parameter VECTOR_WIDTH, default 920, the full vector width.
REQ-003 The block SHALL have parameter VEC_ID_WIDTH, default 8, the vector ID width.
REQ-004 The block SHALL have parameter UNIT_NO, default 4, the number of compare units (2..16).
REQ-005 The block SHALL have parameter SUB_VEC_NO, default ceil(VECTOR_WIDTH/BUS_WIDTH), the number of words per vector.
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock.
REQ-007 The block SHALL have port rst, input, 1 bit, the reset: synchronous, active-high.
REQ-008 The block SHALL have ports up_Vector (input, BUS_WIDTH), up_VecID (input, VEC_ID_WIDTH), up_Valid (input, 1) and up_Last (input, 1), the separated-vector stream from vec_cat.
REQ-009 The block SHALL have port up_Ready, output, 1 bit, meaning a word is accepted this cycle when up_Valid is also high.
REQ-010 The block SHALL have ports dn_Vector (output, BUS_WIDTH), dn_VecID (output, VEC_ID_WIDTH) and dn_Last (output, 1), broadcast to all units.
REQ-011 The block SHALL have port dn_Valid, output, UNIT_NO bits, one-hot valid per unit.
REQ-012 The block SHALL have port dn_Ready, input, UNIT_NO bits, ready per unit.
REQ-013 The block SHALL have port batch_Done, output, 1 bit, a one-cycle pulse when a batch has fully drained.
REQ-014 The block SHALL have port err_Frame, output, 1 bit, a sticky framing-error flag.

Function
REQ-015 The block SHALL hold one output register stage, giving 1-cycle latency from up acceptance to dn presentation.
REQ-016 A downstream beat SHALL complete when dn_Valid[g] and dn_Ready[g] are both high, where g is the granted unit.
REQ-017 The block SHALL drive up_Ready = (output register empty or completing this cycle) and (state != FLUSH) and grant valid.
REQ-018 The FSM SHALL have states IDLE, XFER and FLUSH; the reset state SHALL be IDLE.
REQ-019 In IDLE, the block SHALL select, at most once per cycle, the first unit in round-robin order after the last granted unit (unit 0 first after reset) whose dn_Ready is high, grant it, and enter XFER; with no unit ready, it SHALL stay in IDLE.
REQ-020 The grant SHALL stay locked for exactly SUB_VEC_NO accepted words; the whole vector SHALL go to one unit.
REQ-021 A sub-vector counter SHALL count 0..SUB_VEC_NO-1, increment on each up acceptance and wrap to 0; on wrap the block SHALL release the grant and return to IDLE.
REQ-022 On acceptance of up_Last with counter == SUB_VEC_NO-1, the block SHALL enter FLUSH, and dn_Last SHALL accompany that word.
REQ-023 In FLUSH, once the output register is empty, the block SHALL pulse batch_Done for 1 cycle, enter IDLE and leave the round-robin pointer unchanged.
REQ-024 On up_Last with counter != SUB_VEC_NO-1, the block SHALL set err_Frame, forward the word with dn_Last=1, zero the counter and enter FLUSH.
REQ-025 If dn_Ready[g] drops mid-vector, the block SHALL stall: the output is held stable, up_Ready is low, and there is no re-grant.
REQ-026 dn_Vector, dn_VecID and dn_Last SHALL be stable while dn_Valid is high and unacknowledged.

Reset
REQ-027 On rst, the block SHALL clear dn_Valid, dn_Last, batch_Done, err_Frame and up_Ready; set dn_Vector and dn_VecID to 0; zero the counter; point round-robin to unit 0; and set the state to IDLE.
REQ-028 A reset mid-vector SHALL discard the in-flight vector, with no partial batch_Done.

Configuration
REQ-029 With VEC_DISPATCH_STATS_EN defined, the block SHALL add outputs stat_VecCnt (32 bit, vectors dispatched, saturating) and stat_StallCnt (32 bit, cycles with up_Valid high and up_Ready low, saturating), both cleared by rst.
REQ-030 Without VEC_DISPATCH_STATS_EN, these ports and counters SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-031 The shared package SHALL hold the FSM state encoding (IDLE=0, XFER=1, FLUSH=2) and the SUB_VEC_NO computation function.
REQ-032 The round-robin picker SHALL be a sub-module, rr_pick (request vector and pointer in, one-hot grant out, combinational).

Verification
REQ-033 Stream 8 vectors (SUB_VEC_NO=8, UNIT_NO=4) with all units ready -> vectors go to units 0,1,2,3,0,1,2,3, 8 beats each, with 1-cycle latency.
REQ-034 Hold dn_Ready[1]=0 permanently -> vectors go to units 0,2,3,0; no beat appears on unit 1.
REQ-035 Drop dn_Ready[g] for 5 cycles at beat 3 -> output held, up_Ready low for 5 cycles, no data loss or duplication.
REQ-036 Send up_Last on word 7 of vector 4 -> dn_Last is asserted on that word, and batch_Done pulses 1 cycle after the final handshake.
REQ-037 Send up_Last on word 4 -> err_Frame=1 (sticky), dn_Last=1 on that word, and the next vector starts at counter 0.
REQ-038 Assert rst at beat 5 of a vector -> all outputs return to reset values the next cycle, and the first vector after reset goes to unit 0.

Source files
------------

// File: rtl/vec_dispatch_pkg.sv
// rtl/vec_dispatch_pkg.sv - shared FSM encoding and vector sizing helper for vec_dispatch
package vec_dispatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      XFER  = 2'd1,
      FLUSH = 2'd2
   } state_t;

   function automatic int calc_sub_vec_no(input int vector_width, input int bus_width);
      return (vector_width + bus_width - 1) / bus_width;
   endfunction

endpackage

// File: rtl/vec_dispatch_if.sv
// rtl/vec_dispatch_if.sv - upstream vector stream and broadcast downstream bus for vec_dispatch
interface vec_dispatch_if #(
   parameter int BUS_WIDTH    = 128,
   parameter int VEC_ID_WIDTH = 8,
   parameter int UNIT_NO      = 4
);
   logic [BUS_WIDTH-1:0]    up_Vector;
   logic [VEC_ID_WIDTH-1:0] up_VecID;
   logic                    up_Valid;
   logic                    up_Last;
   logic                    up_Ready;

   logic [BUS_WIDTH-1:0]    dn_Vector;
   logic [VEC_ID_WIDTH-1:0] dn_VecID;
   logic                    dn_Last;
   logic [UNIT_NO-1:0]      dn_Valid;
   logic [UNIT_NO-1:0]      dn_Ready;

   logic                    batch_Done;
   logic                    err_Frame;

   modport slave (
      input  up_Vector, up_VecID, up_Valid, up_Last, dn_Ready,
      output up_Ready, dn_Vector, dn_VecID, dn_Last, dn_Valid, batch_Done, err_Frame
   );

   modport master (
      output up_Vector, up_VecID, up_Valid, up_Last, dn_Ready,
      input  up_Ready, dn_Vector, dn_VecID, dn_Last, dn_Valid, batch_Done, err_Frame
   );

endinterface

// File: rtl/vec_dispatch_rr_pick.sv
// rtl/vec_dispatch_rr_pick.sv - combinational round-robin picker: first request at or after ptr
module rr_pick #(
   parameter int UNIT_NO = 4,
   parameter int PTR_W   = 2
) (
   input  logic [UNIT_NO-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [UNIT_NO-1:0] gnt
);
   localparam logic [PTR_W:0] UNITS = (PTR_W + 1)'(UNIT_NO);

   logic           found;
   logic [PTR_W:0] idx;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < UNIT_NO; i++) begin
         idx = {1'b0, ptr} + (PTR_W + 1)'(i);
         if (idx >= UNITS) begin
            idx = idx - UNITS;
         end
         if (!found && req[idx[PTR_W-1:0]]) begin
            gnt[idx[PTR_W-1:0]] = 1'b1;
            found               = 1'b1;
         end
      end
   end

endmodule

// File: rtl/vec_dispatch.sv
// rtl/vec_dispatch.sv - locks each full vector onto one round-robin picked unit through one output stage
// Optional statistics outputs are built when VEC_DISPATCH_STATS_EN is defined.
module vec_dispatch
   import vec_dispatch_pkg::*;
#(
   parameter int BUS_WIDTH    = 128,
   parameter int VECTOR_WIDTH = 920,
   parameter int VEC_ID_WIDTH = 8,
   parameter int UNIT_NO      = 4,
   parameter int SUB_VEC_NO   = calc_sub_vec_no(VECTOR_WIDTH, BUS_WIDTH)
) (
   input  logic          clk,
   input  logic          rst,
   vec_dispatch_if.slave bus
`ifdef VEC_DISPATCH_STATS_EN
   ,
   output logic [31:0]   stat_VecCnt,
   output logic [31:0]   stat_StallCnt
`endif
);
   localparam int PTR_W = (UNIT_NO > 1) ? $clog2(UNIT_NO) : 1;
   localparam int CNT_W = (SUB_VEC_NO > 1) ? $clog2(SUB_VEC_NO) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SUB_VEC_NO - 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(UNIT_NO - 1);

   state_t                  state;
   logic [UNIT_NO-1:0]      grant;
   logic [UNIT_NO-1:0]      pick;
   logic [UNIT_NO-1:0]      dn_valid;
   logic [PTR_W-1:0]        ptr;
   logic [PTR_W-1:0]        pick_idx;
   logic [CNT_W-1:0]        cnt;
   logic [BUS_WIDTH-1:0]    dn_vector;
   logic [VEC_ID_WIDTH-1:0] dn_vecid;
   logic                    dn_last;
   logic                    batch_done;
   logic                    err_frame;
   logic                    dn_fire;
   logic                    up_ready;
   logic                    up_fire;

   rr_pick #(
      .UNIT_NO (UNIT_NO),
      .PTR_W   (PTR_W)
   ) u_rr_pick (
      .req (bus.dn_Ready),
      .ptr (ptr),
      .gnt (pick)
   );

   // dn_valid carries the unit of the word in the output stage, independent of the lock in grant
   assign dn_fire  = |(dn_valid & bus.dn_Ready);
   assign up_ready = (~|dn_valid || dn_fire) && (state != FLUSH) && (|grant);
   assign up_fire  = bus.up_Valid && up_ready;

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < UNIT_NO; i++) begin
         if (pick[i]) begin
            pick_idx = PTR_W'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         grant      <= '0;
         ptr        <= '0;
         cnt        <= '0;
         dn_valid   <= '0;
         dn_vector  <= '0;
         dn_vecid   <= '0;
         dn_last    <= 1'b0;
         batch_done <= 1'b0;
         err_frame  <= 1'b0;
      end else begin
         batch_done <= 1'b0;

         if (up_fire) begin
            dn_valid  <= grant;
            dn_vector <= bus.up_Vector;
            dn_vecid  <= bus.up_VecID;
            dn_last   <= bus.up_Last;
         end else if (dn_fire) begin
            dn_valid <= '0;
         end

         case (state)
            IDLE: begin
               if (|pick) begin
                  grant <= pick;
                  ptr   <= (pick_idx == PTR_LAST) ? '0 : pick_idx + PTR_W'(1);
                  state <= XFER;
               end
            end
            XFER: begin
               if (up_fire) begin
                  if (bus.up_Last) begin
                     if (cnt != CNT_LAST) begin
                        err_frame <= 1'b1;
                     end
                     cnt   <= '0;
                     grant <= '0;
                     state <= FLUSH;
                  end else if (cnt == CNT_LAST) begin
                     cnt   <= '0;
                     grant <= '0;
                     state <= IDLE;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            FLUSH: begin
               // the round-robin pointer is deliberately left where the batch ended
               if (~|dn_valid || dn_fire) begin
                  batch_done <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.up_Ready   = up_ready;
   assign bus.dn_Valid   = dn_valid;
   assign bus.dn_Vector  = dn_vector;
   assign bus.dn_VecID   = dn_vecid;
   assign bus.dn_Last    = dn_last;
   assign bus.batch_Done = batch_done;
   assign bus.err_Frame  = err_frame;

`ifdef VEC_DISPATCH_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_VecCnt   <= '0;
         stat_StallCnt <= '0;
      end else begin
         if (up_fire && (bus.up_Last || cnt == CNT_LAST) && stat_VecCnt != '1) begin
            stat_VecCnt <= stat_VecCnt + 32'd1;
         end
         if (bus.up_Valid && !up_ready && stat_StallCnt != '1) begin
            stat_StallCnt <= stat_StallCnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_vec_dispatch.sv
// tb/tb_vec_dispatch.sv - directed self-checking bench for vec_dispatch
module tb_vec_dispatch;
   localparam int BW = 128;
   localparam int IW = 8;
   localparam int UN = 4;
   localparam int SV = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   vec_dispatch_if #(.BUS_WIDTH(BW), .VEC_ID_WIDTH(IW), .UNIT_NO(UN)) bus ();

`ifdef VEC_DISPATCH_STATS_EN
   logic [31:0] stat_vec_cnt;
   logic [31:0] stat_stall_cnt;
`endif

   vec_dispatch #(
      .BUS_WIDTH    (BW),
      .VECTOR_WIDTH (920),
      .VEC_ID_WIDTH (IW),
      .UNIT_NO      (UN)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef VEC_DISPATCH_STATS_EN
      ,
      .stat_VecCnt   (stat_vec_cnt),
      .stat_StallCnt (stat_stall_cnt)
`endif
   );

   typedef struct {
      int            unit;
      logic [BW-1:0] data;
      logic [IW-1:0] id;
      logic          last;
      int            cyc;
   } beat_t;

   beat_t         beats[$];
   int            cyc = 0;
   int            batch_cnt = 0;
   int            batch_cyc = -1;
   int            v1_cnt = 0;
   int            lat_cnt = 0;
   int            lat_bad = 0;
   int            n_tests = 0;
   int            n_fail = 0;
   logic          pend = 1'b0;
   logic [BW-1:0] pend_data = '0;

   always @(posedge clk) cyc <= cyc + 1;

   // Records completed handshakes and the one-cycle up-to-dn latency, away from the active edge
   always @(negedge clk) begin
      beat_t b;
      if (pend && !rst) begin
         lat_cnt++;
         if (bus.dn_Vector !== pend_data || bus.dn_Valid == '0) lat_bad++;
      end
      pend      = bus.up_Valid && bus.up_Ready && !rst;
      pend_data = bus.up_Vector;
      if (bus.dn_Valid[1]) v1_cnt++;
      if (bus.batch_Done) begin
         batch_cnt++;
         batch_cyc = cyc;
      end
      if (!rst && (bus.dn_Valid & bus.dn_Ready) != '0) begin
         b.unit = -1;
         for (int i = 0; i < UN; i++) begin
            if (bus.dn_Valid[i] && bus.dn_Ready[i]) b.unit = i;
         end
         b.data = bus.dn_Vector;
         b.id   = bus.dn_VecID;
         b.last = bus.dn_Last;
         b.cyc  = cyc;
         beats.push_back(b);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: observed still running, required finished");
      $fatal(1, "watchdog");
   end

   function automatic logic [BW-1:0] mk(input int v, input int w);
      logic [BW-1:0] d;
      d = {32'hC0DE_0000 + 32'(v), 32'(w), 32'(v * 31 + w), 32'hA5A5_0000 + 32'(v ^ w)};
      return d;
   endfunction

   task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int v, input int w, input bit last);
      int t = 0;
      bus.up_Vector = mk(v, w);
      bus.up_VecID  = IW'(v);
      bus.up_Last   = last;
      bus.up_Valid  = 1'b1;
      @(negedge clk);
      while (!bus.up_Ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) check($sformatf("push_timeout_v%0d_w%0d", v, w), BW'(bus.up_Ready), 1);
      @(posedge clk);
      #1;
      bus.up_Valid = 1'b0;
      bus.up_Last  = 1'b0;
   endtask

   task automatic send_vec(input int v, input int n, input int last_at);
      for (int w = 0; w < n; w++) push(v, w, w == last_at);
   endtask

   task automatic drain();
      repeat (12) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      bus.up_Valid = 1'b0;
      bus.up_Last  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic check_vec(input int b0, input int v, input int n, input int unit, input int last_at);
      for (int w = 0; w < n; w++) begin
         int k = b0 + w;
         if (k >= beats.size()) begin
            check($sformatf("v%0d_w%0d_present", v, w), BW'(beats.size()), BW'(k + 1));
         end else begin
            check($sformatf("v%0d_w%0d_unit", v, w), BW'(beats[k].unit), BW'(unit));
            check($sformatf("v%0d_w%0d_data", v, w), beats[k].data, mk(v, w));
            check($sformatf("v%0d_w%0d_id", v, w), BW'(beats[k].id), BW'(v));
            check($sformatf("v%0d_w%0d_last", v, w), BW'(beats[k].last), BW'(w == last_at));
         end
      end
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_dn_valid"}, BW'(bus.dn_Valid), 0);
      check({pfx, "_dn_last"}, BW'(bus.dn_Last), 0);
      check({pfx, "_up_ready"}, BW'(bus.up_Ready), 0);
      check({pfx, "_batch_done"}, BW'(bus.batch_Done), 0);
      check({pfx, "_err_frame"}, BW'(bus.err_Frame), 0);
      check({pfx, "_dn_vector"}, bus.dn_Vector, 0);
      check({pfx, "_dn_vecid"}, BW'(bus.dn_VecID), 0);
   endtask

   initial begin
      int b0;
      int bc0;
      int v1s;
      int low;
      int lc;
      int exp_units[4];

      bus.up_Vector = '0;
      bus.up_VecID  = '0;
      bus.up_Valid  = 1'b0;
      bus.up_Last   = 1'b0;
      bus.dn_Ready  = '1;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("rst");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // all units ready: strict rotation over 8 vectors
      b0 = beats.size();
      for (int v = 0; v < 8; v++) send_vec(v, SV, -1);
      drain();
      check("a_beats", BW'(beats.size() - b0), 64);
      for (int v = 0; v < 8; v++) check_vec(b0 + SV * v, v, SV, v % 4, -1);

      // unit 1 never ready: it is skipped and never sees a valid
      do_reset();
      bus.dn_Ready = 4'b1101;
      v1s = v1_cnt;
      b0  = beats.size();
      for (int v = 0; v < 4; v++) send_vec(10 + v, SV, -1);
      drain();
      exp_units = '{0, 2, 3, 0};
      check("b_beats", BW'(beats.size() - b0), 32);
      for (int v = 0; v < 4; v++) check_vec(b0 + SV * v, 10 + v, SV, exp_units[v], -1);
      check("b_unit1_valid", BW'(v1_cnt - v1s), 0);
      bus.dn_Ready = '1;

      // ready drops for 5 cycles after beat 3: output held, up_Ready low
      do_reset();
      b0  = beats.size();
      low = 0;
      fork
         send_vec(20, SV, -1);
         begin
            int t = 0;
            while ((beats.size() - b0) < 3 && t < 100) begin
               @(posedge clk);
               t++;
            end
            check("c_stall_arm", BW'(t < 100), 1);
            #1;
            bus.dn_Ready[0] = 1'b0;
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               if (!bus.up_Ready) low++;
               check($sformatf("c_hold_data_%0d", i), bus.dn_Vector, mk(20, 3));
               check($sformatf("c_hold_valid_%0d", i), BW'(bus.dn_Valid), 1);
            end
            @(posedge clk);
            #1;
            bus.dn_Ready[0] = 1'b1;
            check("c_up_ready_low_cycles", BW'(low), 5);
         end
      join
      drain();
      check("c_beats", BW'(beats.size() - b0), 8);
      check_vec(b0, 20, SV, 0, -1);

      // proper up_Last on word 7 of vector 4: dn_Last, batch_Done one cycle later, pointer kept
      do_reset();
      b0  = beats.size();
      bc0 = batch_cnt;
      for (int v = 0; v < 4; v++) send_vec(30 + v, SV, -1);
      send_vec(34, SV, 7);
      drain();
      check("d_beats", BW'(beats.size() - b0), 40);
      for (int v = 0; v < 4; v++) check_vec(b0 + SV * v, 30 + v, SV, v, -1);
      check_vec(b0 + 32, 34, SV, 0, 7);
      check("d_batch_pulses", BW'(batch_cnt - bc0), 1);
      lc = (beats.size() >= b0 + 40) ? beats[b0 + 39].cyc : -100;
      check("d_batch_timing", BW'(batch_cyc), BW'(lc + 1));
      check("d_err_clear", BW'(bus.err_Frame), 0);
      send_vec(35, SV, -1);
      drain();
      check_vec(b0 + 40, 35, SV, 1, -1);

      // early up_Last on word 4: sticky err, counter restarts at 0
      do_reset();
      b0 = beats.size();
      send_vec(40, 5, 4);
      drain();
      check("e_err_set", BW'(bus.err_Frame), 1);
      check_vec(b0, 40, 5, 0, 4);
      send_vec(41, SV, -1);
      send_vec(42, SV, -1);
      drain();
      check("e_beats", BW'(beats.size() - b0), 21);
      check_vec(b0 + 5, 41, SV, 1, -1);
      check_vec(b0 + 13, 42, SV, 2, -1);
      check("e_err_sticky", BW'(bus.err_Frame), 1);

      // reset at beat 5 of a vector: in-flight data discarded, rotation restarts at unit 0
      do_reset();
      b0  = beats.size();
      bc0 = batch_cnt;
      send_vec(50, SV, -1);
      for (int w = 0; w < 5; w++) push(51, w, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset_outputs("f_rst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      send_vec(52, SV, -1);
      drain();
      check("f_beats", BW'(beats.size() - b0), 20);
      check_vec(b0, 50, SV, 0, -1);
      check_vec(b0 + SV, 51, 4, 1, -1);
      check_vec(b0 + 12, 52, SV, 0, -1);
      check("f_no_batch", BW'(batch_cnt - bc0), 0);

      check("latency_errors", BW'(lat_bad), 0);
      check("latency_samples", BW'(lat_cnt > 100), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
